pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that generalises the fixed IF/ID-style latch into a reusable stage boundary with a valid/ready handshake, a 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. Each of IF/ID, ID/EX, EX/MEM and MEM/WB instantiates it with its own payload width. The upstream stage packs its fields into `in_data`, and the downstream stage unpacks `out_data`. Stalls propagate backwards through `in_ready` without a combinational path from `out_ready` to `in_ready`.

---
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage boundary: valid/ready handshake with a two-entry skid buffer,
// synchronous flush with bubble insertion, and a saturating stall counter.
module pipe_stage_reg #(
    parameter int                  DATA_W = 96,
    parameter logic [DATA_W-1:0]   BUBBLE = '0,
    parameter int                  CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic acc;
    logic cons;
    logic stall;

    // in_ready depends only on registered state and flush, so out_ready never reaches it.
    assign in_ready  = !skid_vld_q && !flush;
    assign out_valid = main_vld_q;
    assign out_data  = main_vld_q ? main_data_q : BUBBLE;
    assign stall_cnt = stall_cnt_q;

    assign acc   = in_valid && in_ready;
    assign cons  = main_vld_q && out_ready;
    assign stall = main_vld_q && !out_ready;

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first so no branch can infer a latch.
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q && (cons || !main_vld_q)) begin
            main_vld_d  = 1'b1;
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
        end else if (acc && (cons || !main_vld_q)) begin
            main_vld_d  = 1'b1;
            main_data_d = in_data;
        end else if (acc && main_vld_q && !out_ready) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
        end else if (cons && !acc) begin
            main_vld_d = 1'b0;
        end
    end

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            // NOTE: payload registers are cleared too, giving deterministic contents after reset.
            main_data_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic,
// compared every cycle against a FIFO-of-two reference model.
module tb_pipe_stage_reg;

    localparam int          DW      = 32;
    localparam int          CW      = 4;
    localparam logic [31:0] BUB     = 32'hDEAD_BEEF;
    localparam int unsigned CNT_MAX = 15;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic          cnt_clr;
    logic [CW-1:0] stall_cnt;

    int tests_run;
    int tests_failed;

    // Reference model: the stage is an in-order queue holding at most two entries.
    logic [DW-1:0] mq[$];
    int unsigned   mcnt;

    pipe_stage_reg #(
        .DATA_W (DW),
        .BUBBLE (BUB),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                         input logic fl, input logic clr, input logic rs);
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic          exp_rdy;
        logic          m_acc;
        logic          m_cons;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        rst       = rs;
        #1;
        exp_v   = (mq.size() > 0);
        exp_d   = exp_v ? mq[0] : BUB;
        exp_rdy = (mq.size() < 2) && !fl;
        check("out_valid", 64'(out_valid), 64'(exp_v));
        check("out_data",  64'(out_data),  64'(exp_d));
        check("in_ready",  64'(in_ready),  64'(exp_rdy));
        check("stall_cnt", 64'(stall_cnt), 64'(mcnt));

        m_acc  = iv && exp_rdy;
        m_cons = exp_v && ordy;
        if (!rs) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (fl) begin
                mq.delete();
            end else begin
                if (m_cons) void'(mq.pop_front());
                if (m_acc)  mq.push_back(id);
            end
            if (clr)                                  mcnt = 0;
            else if (exp_v && !ordy && mcnt < CNT_MAX) mcnt = mcnt + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mcnt         = 0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        flush        = 1'b0;
        cnt_clr      = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles while upstream offers data.
        cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Streaming at full rate.
        cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Stall with skid: A, B, C back-to-back, out_ready low for three cycles once A shows.
        cycle(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stall_out_data", 64'(out_data), 64'(32'hA));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1);
        check("after_stall_cnt", 64'(stall_cnt), 64'(3));
        cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush with both entries full; the input offered during flush must vanish.
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h12, 1'b0, 1'b1, 1'b0, 1'b1);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_out_data",  64'(out_data),  64'(BUB));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation: 20 stall cycles, then clear during a stall, then one more stall.
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_cnt", 64'(stall_cnt), 64'(15));
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_cnt", 64'(stall_cnt), 64'(0));
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("one_more_cnt", 64'(stall_cnt), 64'(1));

        // Reset mid-stall with main and skid full.
        cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_cnt",   64'(stall_cnt), 64'(0));
        check("rst_mid_ready", 64'(in_ready),  64'(1));

        // Random traffic with occasional flush, clear and reset.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 63) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
